// File: rtl/sr04_ranging_ctrl_if.sv
// Signal bundle between the HC-SR04 ranging controller and its surroundings:
// request/control inputs, the sensor pins and the measurement results.
`timescale 1ns/1ps
interface sr04_ranging_ctrl_if #(
    parameter int unsigned CM_W = 12
);
    logic            start;
    logic            auto_en;
    logic            echo;
    logic            trig;
    logic [CM_W-1:0] distance_cm;
    logic            valid;
    logic            timeout_err;
    logic            busy;

    // Master drives requests and the echo pin; it sees trigger and results.
    modport master (
        output start, auto_en, echo,
        input  trig, distance_cm, valid, timeout_err, busy
    );

    // Slave is the ranging controller itself.
    modport slave (
        input  start, auto_en, echo,
        output trig, distance_cm, valid, timeout_err, busy
    );
endinterface

// File: rtl/sr04_ranging_ctrl.sv
// HC-SR04 initiator: issues the trigger pulse, times the echo width in
// 1 us ticks, converts it to centimetres and strobes the result (or an
// abort) for one clock. Every measurement ends in a holdoff dead time.
`timescale 1ns/1ps
module sr04_ranging_ctrl #(
    parameter int unsigned TRIG_US         = 10,
    parameter int unsigned US_PER_CM       = 58,
    parameter int unsigned RISE_TIMEOUT_US = 30000,
    parameter int unsigned ECHO_MAX_US     = 25000,
    parameter int unsigned HOLDOFF_US      = 60000,
    parameter int unsigned CM_W            = 12
) (
    input  logic               clk,
    input  logic               reset_p,
    input  logic               clk_usec,
    sr04_ranging_ctrl_if.slave bus
);

    // One shared tick counter covers every timed state, so size it for the
    // longest interval.
    localparam int unsigned MAX_A   = (TRIG_US > RISE_TIMEOUT_US) ? TRIG_US : RISE_TIMEOUT_US;
    localparam int unsigned MAX_B   = (ECHO_MAX_US > HOLDOFF_US) ? ECHO_MAX_US : HOLDOFF_US;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SUB_W   = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_MAX_US - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_US - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(US_PER_CM - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_HOLDOFF   = 3'd4;

    // Centimetre counter increment that sticks at full scale instead of wrapping.
    function automatic logic [CM_W-1:0] sat_inc(input logic [CM_W-1:0] v);
        return (v == {CM_W{1'b1}}) ? v : v + CM_W'(1);
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [CM_W-1:0]  cm_q, cm_d;
    logic [CM_W-1:0]  dist_q, dist_d;
    logic             valid_q, valid_d;
    logic             timeout_err_q, timeout_err_d;
    logic             echo_p0_q, echo_p0_d;
    logic             echo_p1_q, echo_p1_d;
    logic             echo_p2_q, echo_p2_d;
    logic             echo_rise;
    logic             echo_fall;

    // echo_p0/p1 resynchronise the pin; echo_p2 is the previous value for edge detect.
    assign echo_rise = echo_p1_q & ~echo_p2_q;
    assign echo_fall = ~echo_p1_q & echo_p2_q;

    // Next-state, counter and result logic for the ranging sequence.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        sub_d         = sub_q;
        cm_d          = cm_q;
        dist_d        = dist_q;
        valid_d       = 1'b0;
        timeout_err_d = 1'b0;
        echo_p0_d     = bus.echo;
        echo_p1_d     = echo_p0_q;
        echo_p2_d     = echo_p1_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start || bus.auto_en) begin
                    state_d    = S_TRIG;
                    tick_cnt_d = '0;
                end
            end
            S_TRIG: begin
                if (clk_usec) begin
                    if (tick_cnt_q == TRIG_LAST) begin
                        state_d    = S_WAIT_RISE;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WAIT_RISE: begin
                // Only a fresh 0->1 edge starts timing; a stuck-high echo times out.
                if (echo_rise) begin
                    state_d    = S_MEASURE;
                    tick_cnt_d = '0;
                    sub_d      = '0;
                    cm_d       = '0;
                end else if (clk_usec) begin
                    if (tick_cnt_q == RISE_LAST) begin
                        state_d       = S_HOLDOFF;
                        tick_cnt_d    = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_MEASURE: begin
                // A fall on the same cycle as the width limit still reports a distance.
                if (echo_fall) begin
                    state_d    = S_HOLDOFF;
                    tick_cnt_d = '0;
                    dist_d     = cm_q;
                    valid_d    = 1'b1;
                end else if (clk_usec) begin
                    if (tick_cnt_q == ECHO_LAST) begin
                        state_d       = S_HOLDOFF;
                        tick_cnt_d    = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                        if (sub_q == SUB_LAST) begin
                            sub_d = '0;
                            cm_d  = sat_inc(cm_q);
                        end else begin
                            sub_d = sub_q + SUB_W'(1);
                        end
                    end
                end
            end
            S_HOLDOFF: begin
                if (clk_usec) begin
                    if (tick_cnt_q == HOLD_LAST) begin
                        state_d    = S_IDLE;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
            end
        endcase
    end

    // State, counters, result and echo synchroniser registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q       <= S_IDLE;
            tick_cnt_q    <= '0;
            sub_q         <= '0;
            cm_q          <= '0;
            dist_q        <= '0;
            valid_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            echo_p0_q     <= 1'b0;
            echo_p1_q     <= 1'b0;
            echo_p2_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            sub_q         <= sub_d;
            cm_q          <= cm_d;
            dist_q        <= dist_d;
            valid_q       <= valid_d;
            timeout_err_q <= timeout_err_d;
            echo_p0_q     <= echo_p0_d;
            echo_p1_q     <= echo_p1_d;
            echo_p2_q     <= echo_p2_d;
        end
    end

    // trig decodes straight from state so it drops on the same edge that leaves TRIG.
    assign bus.trig        = (state_q == S_TRIG);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.distance_cm = dist_q;
    assign bus.valid       = valid_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/sr04_ranging_ctrl.md
Name: sr04_ranging_ctrl

Overview:
Initiator side of the HC-SR04 ultrasonic ranging interface. It issues the trigger pulse, waits for the sensor's echo and times the echo width in clk_usec ticks. It converts that width to centimetres (58 us per cm) and publishes the result with a one-cycle valid strobe. It sits between the clock_set tick tree (clk_usec input) and display or FND logic, and replaces ad-hoc trigger/echo handling in top-level designs.

Parameters:
TRIG_US, 10, trigger high width in clk_usec ticks
US_PER_CM, 58, echo ticks per reported centimetre
RISE_TIMEOUT_US, 30000, max ticks from trigger end to echo rise
ECHO_MAX_US, 25000, max echo high width before abort
HOLDOFF_US, 60000, dead time after any measurement end before next trigger
CM_W, 12, distance output width

Ports:
clk  in  1  system clock (125 MHz)
reset_p  in  1  reset
clk_usec  in  1  one-clk-wide 1 us tick
start  in  1  single-shot request (level sampled in IDLE)
auto_en  in  1  1 = retrigger automatically after HOLDOFF
echo  in  1  sensor echo, asynchronous
trig  out  1  sensor trigger
distance_cm  out  CM_W  last valid distance
valid  out  1  1-clk strobe, new distance_cm
timeout_err  out  1  1-clk strobe, measurement aborted
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock `clk`. Reset `reset_p` is synchronous and active-high. All state changes happen on posedge clk.
- Reset: state=IDLE. trig, valid, timeout_err and busy are 0. distance_cm=0. All counters are 0. Echo synchroniser flops are 0.
- echo passes through a 2-flop synchroniser plus a previous-value flop. Rise/fall events are derived from the synchronised signal, so they appear 2-3 clk after the pin changes.
- All timing counters advance only on cycles where clk_usec=1.
- FSM states:
  - IDLE: if start=1 or auto_en=1, go to TRIG and clear the tick counter.
  - TRIG: trig=1. After TRIG_US ticks, trig=0, clear the tick counter, go to WAIT_RISE. Trig width is TRIG_US ticks, within ±1 tick of phase.
  - WAIT_RISE: on an echo rise, clear the sub and cm counters and go to MEASURE. If the tick counter reaches RISE_TIMEOUT_US first, pulse timeout_err and go to HOLDOFF. An echo already high on entry does not count; only a 0->1 edge counts.
  - MEASURE: on each tick, increment the sub counter. When sub reaches US_PER_CM-1 on a tick, sub=0 and cm=cm+1 (floor division). On an echo fall, distance_cm<=cm, pulse valid, go to HOLDOFF. If the total width reaches ECHO_MAX_US ticks, pulse timeout_err and go to HOLDOFF; distance_cm is unchanged.
  - HOLDOFF: wait HOLDOFF_US ticks, then go to IDLE. IDLE restarts on the next clk if auto_en=1.
- cm saturates at 2^CM_W-1 and never wraps.
- On timeout, distance_cm keeps its previous value.
- start is ignored while busy. It is not queued.
- valid and timeout_err are mutually exclusive and never asserted in the same cycle.
- Echo fall and the ECHO_MAX limit on the same cycle: the fall wins, so valid is asserted.
- A synchronous reset in any state (including TRIG or MEASURE) forces the reset values on the next posedge, and trig drops immediately.
- Latency: valid asserts 3 clk after the echo pin falls, because of the synchroniser plus the edge detect.

Test Plan:
- Reset check: assert reset_p 5 clk in mid-run -> trig=0, busy=0, distance_cm=0, valid=0, timeout_err=0.
- Basic range: start 1 clk; echo rises 200 us after trig falls and stays high 580 us -> trig high exactly 10 ticks; distance_cm=10; one valid pulse; busy falls 60000 ticks later.
- Division edges: echo widths 57, 58, 116 and 1159 us in separate runs -> distance 0, 1, 2, 19.
- No echo: echo held 0 -> timeout_err pulses once 30000 ticks after trig falls; distance_cm keeps its prior value (10); no valid.
- Stuck and long echo: echo high before start -> WAIT_RISE times out. Echo high 26000 us -> timeout_err at 25000 ticks, no valid.
- Control: start re-pulsed during MEASURE is ignored, giving one valid only. auto_en=1 -> second trig starts 60000 ticks plus 1-2 clk after the first measurement ends. reset_p during MEASURE -> trig=0, IDLE, no valid.
